// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard beside ID: tracks in-flight destination registers in EX/MEM/WB
// and stalls on load-use and ID-resolved register-branch hazards that forwarding cannot cover.
module hazard_scoreboard #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ID_Valid,
  input  logic [3:0]         ID_rs,
  input  logic [3:0]         ID_rt,
  input  logic               ID_UsesRs,
  input  logic               ID_UsesRt,
  input  logic               ID_StoreData,
  input  logic               ID_Branch,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic [3:0]         ID_destReg,
  input  logic               Flush,
  input  logic               Freeze,
  output logic               Stall,
  output logic [15:0]        Pending,
  output logic [COUNT_W-1:0] StallCount
);

  logic       ex_v, mem_v, wb_v;
  logic [3:0] ex_dest, mem_dest, wb_dest;
  logic       ex_load, mem_load;

  logic       rs_hit_ex, rt_hit_ex, rs_hit_mem;
  logic       luh, brh;
  logic       fill_v;

  // Per-slot source matches; a slot only counts when its valid bit is set.
  assign rs_hit_ex  = ex_v  && (ID_rs == ex_dest);
  assign rt_hit_ex  = ex_v  && (ID_rt == ex_dest);
  assign rs_hit_mem = mem_v && (ID_rs == mem_dest);

  // Store data in rt is served by MEM-MEM forwarding, so it never load-use stalls.
  assign luh = ID_Valid && ex_load &&
               ((ID_UsesRs && rs_hit_ex) ||
                (ID_UsesRt && !ID_StoreData && rt_hit_ex));

  assign brh = ID_Valid && ID_Branch && ID_UsesRs &&
               (rs_hit_ex || (rs_hit_mem && mem_load));

  assign Stall = (luh || brh) && !Flush;

  // Register 0 is never recorded, so it can neither stall nor show as pending.
  assign fill_v = ID_Valid && ID_RegWrite && (ID_destReg != 4'd0) && !Stall && !Flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v     <= 1'b0;
      mem_v    <= 1'b0;
      wb_v     <= 1'b0;
      ex_dest  <= 4'd0;
      mem_dest <= 4'd0;
      wb_dest  <= 4'd0;
      ex_load  <= 1'b0;
      mem_load <= 1'b0;
    end else if (!Freeze) begin
      wb_v     <= mem_v;
      wb_dest  <= mem_dest;
      mem_v    <= ex_v;
      mem_dest <= ex_dest;
      mem_load <= ex_load;
      ex_v     <= fill_v;
      ex_dest  <= ID_destReg;
      ex_load  <= ID_MemRead;
    end
  end

  always_comb begin
    Pending = 16'h0000;
    if (ex_v)  Pending[ex_dest]  = 1'b1;
    if (mem_v) Pending[mem_dest] = 1'b1;
    if (wb_v)  Pending[wb_dest]  = 1'b1;
    Pending[0] = 1'b0;
  end

  // Counts only stalls that actually hold the pipe; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
    end else if (Stall && !Freeze && (StallCount != {COUNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst, rst_s;
  logic        ID_Valid, ID_UsesRs, ID_UsesRt, ID_StoreData, ID_Branch, ID_RegWrite, ID_MemRead;
  logic [3:0]  ID_rs, ID_rt, ID_destReg;
  logic        Flush, Freeze;
  logic        Stall, Stall_s;
  logic [15:0] Pending, Pending_s;
  logic [15:0] StallCount;
  logic [1:0]  StallCount_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic [15:0] pend;
    logic [15:0] cnt;
    logic [1:0]  scnt;
    string       name;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .ID_Valid(ID_Valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_StoreData(ID_StoreData),
    .ID_Branch(ID_Branch), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_destReg(ID_destReg), .Flush(Flush), .Freeze(Freeze),
    .Stall(Stall), .Pending(Pending), .StallCount(StallCount)
  );

  // Narrow counter instance to exercise saturation in a handful of cycles.
  hazard_scoreboard #(.COUNT_W(2)) dut_s (
    .clk(clk), .rst(rst_s), .ID_Valid(ID_Valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_StoreData(ID_StoreData),
    .ID_Branch(ID_Branch), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_destReg(ID_destReg), .Flush(Flush), .Freeze(Freeze),
    .Stall(Stall_s), .Pending(Pending_s), .StallCount(StallCount_s)
  );

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (Stall !== e.stall) begin
        errors++;
        $display("FAIL %s stall: got %b want %b", e.name, Stall, e.stall);
      end
      checks++;
      if (Pending !== e.pend) begin
        errors++;
        $display("FAIL %s pending: got %h want %h", e.name, Pending, e.pend);
      end
      checks++;
      if (StallCount !== e.cnt) begin
        errors++;
        $display("FAIL %s count: got %0d want %0d", e.name, StallCount, e.cnt);
      end
      checks++;
      if (StallCount_s !== e.scnt) begin
        errors++;
        $display("FAIL %s small_count: got %0d want %0d", e.name, StallCount_s, e.scnt);
      end
    end
  end

  task automatic set_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                        input logic urs, input logic urt, input logic sd, input logic br,
                        input logic rw, input logic mr, input logic [3:0] dst);
    ID_Valid = v; ID_rs = rs; ID_rt = rt; ID_UsesRs = urs; ID_UsesRt = urt;
    ID_StoreData = sd; ID_Branch = br; ID_RegWrite = rw; ID_MemRead = mr; ID_destReg = dst;
  endtask

  task automatic nop();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic ld(input logic [3:0] d);
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, d);
  endtask

  task automatic alu(input logic [3:0] d, input logic [3:0] rs, input logic [3:0] rt, input logic urt);
    set_id(1'b1, rs, rt, 1'b1, urt, 1'b0, 1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic brn(input logic [3:0] rs);
    set_id(1'b1, rs, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic st(input logic [3:0] rs, input logic [3:0] rt);
    set_id(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  // Inputs are already applied for this cycle; queue what the DUT must show, then advance.
  task automatic step(input logic s, input logic [15:0] p, input logic [15:0] c,
                      input logic [1:0] sc, input string nm);
    exp_t e;
    e.stall = s; e.pend = p; e.cnt = c; e.scnt = sc; e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_s = 1'b1; Flush = 1'b0; Freeze = 1'b0;
    nop();
    @(posedge clk); #1;

    // Reset held with a would-be hazard on the inputs
    ld(4'd3);           step(1'b0, 16'h0000, 16'd0, 2'd0, "reset");
    rst = 1'b0;

    // Load-use on rs
    ld(4'd3);           step(1'b0, 16'h0000, 16'd0, 2'd0, "lu_load");
    alu(4'd5, 4'd3, 4'd4, 1'b1); step(1'b1, 16'h0008, 16'd0, 2'd0, "lu_stall");
    alu(4'd5, 4'd3, 4'd4, 1'b1); step(1'b0, 16'h0008, 16'd1, 2'd0, "lu_release");
    nop();              step(1'b0, 16'h0028, 16'd1, 2'd0, "lu_bubble");
    nop();              step(1'b0, 16'h0020, 16'd1, 2'd0, "lu_drain1");
    nop();              step(1'b0, 16'h0020, 16'd1, 2'd0, "lu_drain2");
    nop();              step(1'b0, 16'h0000, 16'd1, 2'd0, "lu_empty");

    // Store data from a load: no stall
    ld(4'd3);           step(1'b0, 16'h0000, 16'd1, 2'd0, "st_load");
    st(4'd1, 4'd3);     step(1'b0, 16'h0008, 16'd1, 2'd0, "st_nostall");
    nop();              step(1'b0, 16'h0008, 16'd1, 2'd0, "st_pend_mem");
    nop();              step(1'b0, 16'h0008, 16'd1, 2'd0, "st_pend_wb");
    nop();              step(1'b0, 16'h0000, 16'd1, 2'd0, "st_cleared");

    // Branch on ALU result: one stall
    alu(4'd2, 4'd1, 4'd0, 1'b0); step(1'b0, 16'h0000, 16'd1, 2'd0, "bra_alu");
    brn(4'd2);          step(1'b1, 16'h0004, 16'd1, 2'd0, "bra_stall");
    brn(4'd2);          step(1'b0, 16'h0004, 16'd2, 2'd0, "bra_release");
    nop();              step(1'b0, 16'h0004, 16'd2, 2'd0, "bra_drain");
    nop();              step(1'b0, 16'h0000, 16'd2, 2'd0, "bra_empty");

    // Reset the counter, then branch on load result: two stalls
    rst = 1'b1; nop();  step(1'b0, 16'h0000, 16'd2, 2'd0, "rst_pulse");
    rst = 1'b0;
    ld(4'd2);           step(1'b0, 16'h0000, 16'd0, 2'd0, "brl_load");
    brn(4'd2);          step(1'b1, 16'h0004, 16'd0, 2'd0, "brl_stall_ex");
    brn(4'd2);          step(1'b1, 16'h0004, 16'd1, 2'd0, "brl_stall_mem");
    brn(4'd2);          step(1'b0, 16'h0004, 16'd2, 2'd0, "brl_release");
    nop();              step(1'b0, 16'h0000, 16'd2, 2'd0, "brl_empty");

    // Register 0 never tracked
    ld(4'd0);           step(1'b0, 16'h0000, 16'd2, 2'd0, "r0_load");
    alu(4'd6, 4'd0, 4'd0, 1'b1); step(1'b0, 16'h0000, 16'd2, 2'd0, "r0_read");
    nop();              step(1'b0, 16'h0040, 16'd2, 2'd0, "r0_alu_ex");
    nop();              step(1'b0, 16'h0040, 16'd2, 2'd0, "r0_alu_mem");
    nop();              step(1'b0, 16'h0040, 16'd2, 2'd0, "r0_alu_wb");
    nop();              step(1'b0, 16'h0000, 16'd2, 2'd0, "r0_empty");

    // Load-use held by Freeze for 4 cycles
    ld(4'd7);           step(1'b0, 16'h0000, 16'd2, 2'd0, "frz_load");
    Freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu(4'd8, 4'd7, 4'd0, 1'b0); step(1'b1, 16'h0080, 16'd2, 2'd0, "frz_hold");
    end
    Freeze = 1'b0;
    alu(4'd8, 4'd7, 4'd0, 1'b0); step(1'b1, 16'h0080, 16'd2, 2'd0, "frz_stall");
    alu(4'd8, 4'd7, 4'd0, 1'b0); step(1'b0, 16'h0080, 16'd3, 2'd0, "frz_release");
    nop();              step(1'b0, 16'h0180, 16'd3, 2'd0, "frz_both");
    nop();              step(1'b0, 16'h0100, 16'd3, 2'd0, "frz_drain1");
    nop();              step(1'b0, 16'h0100, 16'd3, 2'd0, "frz_drain2");
    nop();              step(1'b0, 16'h0000, 16'd3, 2'd0, "frz_empty");

    // Flush beats the hazard and inserts a bubble
    ld(4'd9);           step(1'b0, 16'h0000, 16'd3, 2'd0, "fl_load");
    Flush = 1'b1;
    alu(4'd10, 4'd9, 4'd0, 1'b0); step(1'b0, 16'h0200, 16'd3, 2'd0, "fl_nostall");
    Flush = 1'b0;
    nop();              step(1'b0, 16'h0200, 16'd3, 2'd0, "fl_bubble");
    nop();              step(1'b0, 16'h0200, 16'd3, 2'd0, "fl_drain");
    nop();              step(1'b0, 16'h0000, 16'd3, 2'd0, "fl_empty");

    // Load-use through rt
    ld(4'd11);          step(1'b0, 16'h0000, 16'd3, 2'd0, "rt_load");
    alu(4'd12, 4'd1, 4'd11, 1'b1); step(1'b1, 16'h0800, 16'd3, 2'd0, "rt_stall");
    alu(4'd12, 4'd1, 4'd11, 1'b1); step(1'b0, 16'h0800, 16'd4, 2'd0, "rt_release");
    nop();              step(1'b0, 16'h1800, 16'd4, 2'd0, "rt_both");
    nop();              step(1'b0, 16'h1000, 16'd4, 2'd0, "rt_drain1");
    nop();              step(1'b0, 16'h1000, 16'd4, 2'd0, "rt_drain2");
    nop();              step(1'b0, 16'h0000, 16'd4, 2'd0, "rt_empty");

    // Reset asserted mid-stall
    ld(4'd13);          step(1'b0, 16'h0000, 16'd4, 2'd0, "mrst_load");
    rst = 1'b1;
    alu(4'd14, 4'd13, 4'd0, 1'b0); step(1'b1, 16'h2000, 16'd4, 2'd0, "mrst_stall");
    rst = 1'b0;
    alu(4'd14, 4'd13, 4'd0, 1'b0); step(1'b0, 16'h0000, 16'd0, 2'd0, "mrst_cleared");
    nop();              step(1'b0, 16'h4000, 16'd0, 2'd0, "mrst_alu_ex");
    nop();              step(1'b0, 16'h4000, 16'd0, 2'd0, "mrst_alu_mem");
    nop();              step(1'b0, 16'h4000, 16'd0, 2'd0, "mrst_alu_wb");
    nop();              step(1'b0, 16'h0000, 16'd0, 2'd0, "mrst_empty");

    // Saturation: narrow counter reaches 2 then sees 3 more stalls
    rst_s = 1'b0;
    ld(4'd3);           step(1'b0, 16'h0000, 16'd0, 2'd0, "sat_load1");
    brn(4'd3);          step(1'b1, 16'h0008, 16'd0, 2'd0, "sat_s1");
    brn(4'd3);          step(1'b1, 16'h0008, 16'd1, 2'd1, "sat_s2");
    ld(4'd3);           step(1'b0, 16'h0008, 16'd2, 2'd2, "sat_load2");
    brn(4'd3);          step(1'b1, 16'h0008, 16'd2, 2'd2, "sat_s3");
    brn(4'd3);          step(1'b1, 16'h0008, 16'd3, 2'd3, "sat_s4");
    ld(4'd3);           step(1'b0, 16'h0008, 16'd4, 2'd3, "sat_load3");
    brn(4'd3);          step(1'b1, 16'h0008, 16'd4, 2'd3, "sat_s5");
    nop();              step(1'b0, 16'h0008, 16'd5, 2'd3, "sat_hold1");
    nop();              step(1'b0, 16'h0008, 16'd5, 2'd3, "sat_hold2");
    nop();              step(1'b0, 16'h0000, 16'd5, 2'd3, "sat_hold3");

    begin
      int guard = 0;
      while (q.size() > 0 && guard < 10) begin
        @(posedge clk);
        guard++;
      end
      if (q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
